// File: rtl/pixel_array_sequencer.sv
// Frame sequencer for the pixel array: ERASE, EXPOSE, CONVERT (ramp), READ.
// Ports: clk/reset; start/continuous/abort/exp_time control; phase outputs
//   erase/expose/bias_en/ramp_en/read/count_oe/count; row capture
//   row_data_in -> row_data_out/row_idx/row_valid with row_ready handshake;
//   status busy/frame_done/frame_cnt. All outputs registered.
module pixel_array_sequencer #(
    parameter int N_ROWS   = 2,
    parameter int ROW_PIX  = 2,
    parameter int DW       = 8,
    parameter int T_ERASE  = 5,
    parameter int T_SETTLE = 2,
    localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [15:0]           exp_time,
    output logic                  erase,
    output logic                  expose,
    output logic                  bias_en,
    output logic                  ramp_en,
    output logic [N_ROWS-1:0]     read,
    output logic                  count_oe,
    output logic [DW-1:0]         count,
    input  logic [ROW_PIX*DW-1:0] row_data_in,
    output logic [ROW_PIX*DW-1:0] row_data_out,
    output logic [RW-1:0]         row_idx,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_GAP, S_DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [15:0] timer;
    logic [15:0] exp_lat;
    logic [RW-1:0] row_r;
    logic        go_erase;

    // A frame starts from IDLE on start, or back-to-back from the
    // frame_done cycle when continuous is set.
    assign go_erase = ((state == S_IDLE) && start) ||
                      ((state == S_DONE) && continuous);

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state        <= S_IDLE;
            nxt          <= S_IDLE;
            timer        <= '0;
            row_r        <= '0;
            erase        <= 1'b0;
            expose       <= 1'b0;
            bias_en      <= 1'b0;
            ramp_en      <= 1'b0;
            read         <= '0;
            count_oe     <= 1'b1;
            count        <= '0;
            row_data_out <= '0;
            row_idx      <= '0;
            row_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            // abort keeps the completed-frame count
            if (reset) begin
                frame_cnt <= '0;
                exp_lat   <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (go_erase) begin
                state   <= S_ERASE;
                erase   <= 1'b1;
                busy    <= 1'b1;
                timer   <= 16'(T_ERASE - 1);
                exp_lat <= exp_time;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_ERASE: begin
                        if (timer == 16'd0) begin
                            erase <= 1'b0;
                            state <= S_GAP;
                            nxt   <= S_EXPOSE;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    S_EXPOSE: begin
                        if (timer == 16'd0) begin
                            expose  <= 1'b0;
                            bias_en <= 1'b0;
                            state   <= S_GAP;
                            nxt     <= S_CONVERT;
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                    S_CONVERT: begin
                        // the ramp ends on the top code, so count never wraps
                        if (count == '1) begin
                            ramp_en <= 1'b0;
                            count   <= '0;
                            state   <= S_GAP;
                            nxt     <= S_READ;
                        end else begin
                            count <= count + DW'(1);
                        end
                    end
                    S_READ: begin
                        if (row_valid && row_ready) begin
                            row_valid <= 1'b0;
                            read      <= '0;
                            count_oe  <= 1'b1;
                            state     <= S_GAP;
                            if (row_r == RW'(N_ROWS - 1)) begin
                                row_r <= '0;
                                nxt   <= S_DONE;
                            end else begin
                                row_r <= row_r + RW'(1);
                                nxt   <= S_READ;
                            end
                        end else if (!row_valid) begin
                            // timer counts READ cycles already elapsed
                            if (timer == 16'(T_SETTLE - 1)) begin
                                row_data_out <= row_data_in;
                                row_idx      <= row_r;
                                row_valid    <= 1'b1;
                            end else begin
                                timer <= timer + 16'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        state <= nxt;
                        unique case (nxt)
                            S_EXPOSE: begin
                                expose  <= 1'b1;
                                bias_en <= 1'b1;
                                timer   <= (exp_lat == 16'd0) ? 16'd0
                                         : exp_lat - 16'd1;
                            end
                            S_CONVERT: begin
                                ramp_en <= 1'b1;
                                count   <= '0;
                            end
                            S_READ: begin
                                read     <= N_ROWS'(1) << row_r;
                                count_oe <= 1'b0;
                                timer    <= '0;
                            end
                            S_DONE: begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                            end
                            default: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
